// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared widths, sizes and the load-return FIFO entry type
package regfile_wb_ctrl_pkg;
    localparam int BITS = 16;
    localparam int RBITS = 4;
    localparam int NREG = 16;
    localparam int LDQ_DEPTH = 2;
    localparam logic [RBITS-1:0] REG_ZERO = '0;
    localparam int CW = $clog2(LDQ_DEPTH) + 1;
    localparam int BCW = $clog2(NREG) + 1;
    typedef struct packed {
        logic [RBITS-1:0] rd;
        logic [BITS-1:0] data;
    } wb_item_t;
endpackage

// File: rtl/regfile_wb_ctrl_fifo.sv
// wb_fifo: synchronous FIFO holding returned loads until the write port is free
module wb_fifo #(
    parameter int W = 20,
    parameter int DEPTH = 2,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d = wp_q + AW'(push);
        rp_d = rp_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q <= '0;
            rp_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            count_q <= count_d;
        end
    end

    assign dout = mem_q[rp_q];
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-port arbiter between execute and load return, plus load scoreboard
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             ex_valid,
    input  logic [RBITS-1:0] ex_rd,
    input  logic [BITS-1:0]  ex_data,
    output logic             ex_ready,
    input  logic             ld_issue,
    input  logic [RBITS-1:0] ld_issue_rd,
    output logic             ld_issue_ok,
    input  logic             ld_valid,
    input  logic [RBITS-1:0] ld_rd,
    input  logic [BITS-1:0]  ld_data,
    output logic             ld_ready,
    input  logic [RBITS-1:0] rs1,
    input  logic [RBITS-1:0] rs2,
    output logic             stall,
    output logic             rf_we,
    output logic [RBITS-1:0] rf_rd,
    output logic [BITS-1:0]  rf_din
);
    wb_item_t head;
    logic fifo_full, fifo_empty, push, pop;
    logic [CW-1:0] fifo_count;
    logic [NREG-1:0] busy_q, busy_d;
    logic [BCW-1:0] busy_cnt;
    logic [BCW:0] outstanding;
    logic rf_we_q, rf_we_d;
    logic [RBITS-1:0] rf_rd_q, rf_rd_d, cm_rd;
    logic [BITS-1:0] rf_din_q, rf_din_d, cm_data;

    wb_fifo #(.W($bits(wb_item_t)), .DEPTH(LDQ_DEPTH), .CW(CW)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
        .din({ld_rd, ld_data}), .dout(head),
        .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREG; i++) busy_cnt = busy_cnt + BCW'(busy_q[i]);
    end

    // Every outstanding load has a reserved FIFO slot, so returns never back up
    assign outstanding = (BCW+1)'(busy_cnt) + (BCW+1)'(fifo_count);
    assign ld_issue_ok = run & ~busy_q[ld_issue_rd] & (outstanding < (BCW+1)'(LDQ_DEPTH));
    assign ld_ready = ~fifo_full;
    assign push = ld_valid & ~fifo_full;
    assign pop = run & ~fifo_empty;
    assign ex_ready = run & fifo_empty & ex_valid & ~busy_q[ex_rd];
    assign stall = (rs1 != REG_ZERO & busy_q[rs1]) | (rs2 != REG_ZERO & busy_q[rs2]);

    always_comb begin
        cm_rd = pop ? head.rd : ex_rd;
        cm_data = pop ? head.data : ex_data;
        rf_we_d = (pop | ex_ready) & (cm_rd != REG_ZERO);
        rf_rd_d = rf_we_d ? cm_rd : rf_rd_q;
        rf_din_d = rf_we_d ? cm_data : rf_din_q;
        busy_d = busy_q;
        if (pop) busy_d[head.rd] = 1'b0;
        if (ld_issue & ld_issue_ok & ld_issue_rd != REG_ZERO) busy_d[ld_issue_rd] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            rf_we_q <= 1'b0;
            rf_rd_q <= '0;
            rf_din_q <= '0;
        end else begin
            busy_q <= busy_d;
            rf_we_q <= rf_we_d;
            rf_rd_q <= rf_rd_d;
            rf_din_q <= rf_din_d;
        end
    end

    assign rf_we = rf_we_q;
    assign rf_rd = rf_rd_q;
    assign rf_din = rf_din_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus an async-reset sequence for regfile_wb_ctrl
module tb_regfile_wb_ctrl;
    logic clk = 0, rst_n = 0, run = 0;
    logic ex_valid = 0, ld_issue = 0, ld_valid = 0;
    logic [3:0] ex_rd = 0, ld_issue_rd = 0, ld_rd = 0, rs1 = 0, rs2 = 0;
    logic [15:0] ex_data = 0, ld_data = 0;
    logic ex_ready, ld_issue_ok, ld_ready, stall, rf_we;
    logic [3:0] rf_rd;
    logic [15:0] rf_din;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ok(ld_issue_ok),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rs1(rs1), .rs2(rs2), .stall(stall),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din)
    );

    typedef struct {
        logic run, exv, lis, ldv;
        logic [3:0] exrd, lisrd, ldrd, rs1, rs2;
        logic [15:0] exd, ldd;
        logic e_exr, e_iok, e_ldr, e_stl, e_we;
        logic [3:0] e_rd;
        logic [15:0] e_din;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int exv, int exrd, int exd, int lis, int lisrd,
                                int ldv, int ldrd, int ldd, int s1, int s2,
                                int exr, int iok, int ldr, int stl, int we, int rd, int din);
        vec_t v;
        v.run = 1'(r); v.exv = 1'(exv); v.exrd = 4'(exrd); v.exd = 16'(exd);
        v.lis = 1'(lis); v.lisrd = 4'(lisrd);
        v.ldv = 1'(ldv); v.ldrd = 4'(ldrd); v.ldd = 16'(ldd);
        v.rs1 = 4'(s1); v.rs2 = 4'(s2);
        v.e_exr = 1'(exr); v.e_iok = 1'(iok); v.e_ldr = 1'(ldr); v.e_stl = 1'(stl);
        v.e_we = 1'(we); v.e_rd = 4'(rd); v.e_din = 16'(din);
        return v;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(int i, vec_t v);
        run = v.run; ex_valid = v.exv; ex_rd = v.exrd; ex_data = v.exd;
        ld_issue = v.lis; ld_issue_rd = v.lisrd;
        ld_valid = v.ldv; ld_rd = v.ldrd; ld_data = v.ldd;
        rs1 = v.rs1; rs2 = v.rs2;
        #1;
        chk($sformatf("v%0d ex_ready", i), 16'(ex_ready), 16'(v.e_exr));
        chk($sformatf("v%0d ld_issue_ok", i), 16'(ld_issue_ok), 16'(v.e_iok));
        chk($sformatf("v%0d ld_ready", i), 16'(ld_ready), 16'(v.e_ldr));
        chk($sformatf("v%0d stall", i), 16'(stall), 16'(v.e_stl));
        @(posedge clk); #1;
        chk($sformatf("v%0d rf_we", i), 16'(rf_we), 16'(v.e_we));
        chk($sformatf("v%0d rf_rd", i), 16'(rf_rd), 16'(v.e_rd));
        chk($sformatf("v%0d rf_din", i), rf_din, v.e_din);
    endtask

    initial begin
        //            run ex:v rd data    lis rd ld:v rd data    rs1 rs2 exr iok ldr stl we rd din
        vecs.push_back(mk(1, 0, 0, 0,      0, 5, 0, 0, 0,       0, 0,   0, 1, 1, 0,  0, 0, 0));
        vecs.push_back(mk(1, 1, 3, 'h1234, 0, 0, 0, 0, 0,       0, 0,   1, 1, 1, 0,  1, 3, 'h1234));
        vecs.push_back(mk(1, 0, 0, 0,      1, 7, 0, 0, 0,       0, 0,   0, 1, 1, 0,  0, 3, 'h1234));
        vecs.push_back(mk(1, 1, 7, 'h5555, 0, 7, 0, 0, 0,       7, 0,   0, 0, 1, 1,  0, 3, 'h1234));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 7, 'hBEEF,  7, 0,   0, 1, 1, 1,  0, 3, 'h1234));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       7, 0,   0, 0, 1, 1,  1, 7, 'hBEEF));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       7, 0,   0, 1, 1, 0,  0, 7, 'hBEEF));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 9, 'hAAAA,  0, 0,   0, 1, 1, 0,  0, 7, 'hBEEF));
        vecs.push_back(mk(1, 1, 10, 'h0A0A, 0, 0, 0, 0, 0,      0, 0,   0, 1, 1, 0,  1, 9, 'hAAAA));
        vecs.push_back(mk(1, 1, 10, 'h0A0A, 0, 0, 0, 0, 0,      0, 0,   1, 1, 1, 0,  1, 10, 'h0A0A));
        vecs.push_back(mk(1, 0, 0, 0,      1, 4, 0, 0, 0,       0, 0,   0, 1, 1, 0,  0, 10, 'h0A0A));
        vecs.push_back(mk(1, 0, 0, 0,      1, 6, 0, 0, 0,       0, 0,   0, 1, 1, 0,  0, 10, 'h0A0A));
        vecs.push_back(mk(1, 0, 0, 0,      1, 8, 0, 0, 0,       0, 6,   0, 0, 1, 1,  0, 10, 'h0A0A));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 4, 'h4444,  0, 0,   0, 0, 1, 0,  0, 10, 'h0A0A));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 6, 'h6666,  0, 0,   0, 0, 1, 0,  1, 4, 'h4444));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       0, 0,   0, 0, 1, 0,  1, 6, 'h6666));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 4, 'h0044,  0, 0,   0, 1, 1, 0,  0, 6, 'h6666));
        vecs.push_back(mk(1, 0, 0, 0,      1, 4, 0, 0, 0,       4, 0,   0, 1, 1, 0,  1, 4, 'h0044));
        vecs.push_back(mk(1, 0, 0, 0,      0, 4, 0, 0, 0,       4, 0,   0, 0, 1, 1,  0, 4, 'h0044));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 4, 'h0444,  4, 0,   0, 1, 1, 1,  0, 4, 'h0044));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       4, 0,   0, 0, 1, 1,  1, 4, 'h0444));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       4, 0,   0, 1, 1, 0,  0, 4, 'h0444));
        vecs.push_back(mk(1, 1, 0, 'h9999, 0, 0, 0, 0, 0,       0, 0,   1, 1, 1, 0,  0, 4, 'h0444));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 1, 11, 'hB0B0, 0, 0,   0, 0, 1, 0,  0, 4, 'h0444));
        vecs.push_back(mk(0, 1, 2, 'h2222, 0, 0, 1, 12, 'hC0C0, 0, 0,   0, 0, 1, 0,  0, 4, 'h0444));
        vecs.push_back(mk(0, 0, 0, 0,      0, 0, 1, 13, 'hD0D0, 0, 0,   0, 0, 0, 0,  0, 4, 'h0444));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 13, 'hD0D0, 0, 0,   0, 0, 0, 0,  1, 11, 'hB0B0));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 1, 13, 'hD0D0, 0, 0,   0, 1, 1, 0,  1, 12, 'hC0C0));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       0, 0,   0, 1, 1, 0,  1, 13, 'hD0D0));
        vecs.push_back(mk(1, 0, 0, 0,      0, 0, 0, 0, 0,       0, 0,   0, 1, 1, 0,  0, 13, 'hD0D0));

        #1;
        chk("async reset rf_we", 16'(rf_we), 16'h0);
        chk("async reset ld_ready", 16'(ld_ready), 16'h1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset mid-stream: one load outstanding, one return parked with run low
        run = 1; ld_issue = 1; ld_issue_rd = 5; rs1 = 5;
        @(posedge clk); #1;
        ld_issue = 0; run = 0; ld_valid = 1; ld_rd = 9; ld_data = 'h9090;
        @(posedge clk); #1;
        ld_valid = 0;
        #1;
        chk("pre-reset stall", 16'(stall), 16'h1);
        chk("pre-reset ld_issue_ok", 16'(ld_issue_ok), 16'h0);
        #2 rst_n = 0;
        #1;
        chk("mid reset stall", 16'(stall), 16'h0);
        chk("mid reset rf_rd", 16'(rf_rd), 16'h0);
        chk("mid reset rf_din", rf_din, 16'h0);
        rst_n = 1; run = 1;
        #1;
        chk("post reset ld_issue_ok", 16'(ld_issue_ok), 16'h1);
        @(posedge clk); #1;
        chk("post reset no pop rf_we", 16'(rf_we), 16'h0);
        chk("post reset stall", 16'(stall), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
